// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment decoder: active-high glyph table,
// all-lit / all-dark patterns and segment bit positions.
package seven_seg_pkg;

  // Segment bit positions within a gfedcba pattern
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
  localparam logic [6:0] SEG_ALL_OFF = 7'h00;

  // Active-high gfedcba glyphs, indexed by digit code (entry 15 listed first)
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, // F
    7'h79, // E
    7'h5E, // d
    7'h39, // C
    7'h7C, // b
    7'h77, // A
    7'h6F, // 9
    7'h7F, // 8
    7'h07, // 7
    7'h7D, // 6
    7'h6D, // 5
    7'h66, // 4
    7'h4F, // 3
    7'h5B, // 2
    7'h06, // 1
    7'h3F  // 0
  };

  // True for codes 10..15, which only show a glyph when hex display is enabled
  function automatic logic is_hex_code(input logic [3:0] code);
    return (code > 4'd9);
  endfunction

endpackage

// File: rtl/seven_seg_lut.sv
// Combinational digit-to-glyph lookup producing an active-high gfedcba pattern.
module seven_seg_lut
  import seven_seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  // Table lookup; codes 10..15 go dark when hex display is disabled
  always_comb begin
    pattern = SEG_LUT[digit];
    if (!HEX_EN && is_hex_code(digit)) begin
      pattern = SEG_ALL_OFF;
    end
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Registered BCD/hex to seven-segment decoder with lamp-test and blanking
// overrides and selectable output polarity. One clock of latency.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg
);

  // Map an active-high pattern onto the board's segment drive polarity
  function automatic logic [6:0] apply_polarity(input logic [6:0] pat);
    return ACTIVE_LOW ? ~pat : pat;
  endfunction

  logic [6:0] glyph_p0;
  logic [6:0] pattern_p0;

  seven_seg_lut #(
    .HEX_EN (HEX_EN)
  ) u_lut (
    .digit   (digit),
    .pattern (glyph_p0)
  );

  // Override priority: lamp test lights everything, blank darkens everything
  always_comb begin
    pattern_p0 = glyph_p0;
    if (lamp_test) begin
      pattern_p0 = SEG_ALL_ON;
    end else if (blank) begin
      pattern_p0 = SEG_ALL_OFF;
    end
  end

  // ---- stage p0 -> p1: output register, dark while reset is held ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= apply_polarity(SEG_ALL_OFF);
    end else begin
      seg <= apply_polarity(pattern_p0);
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder covering three parameterisations
// driven from shared inputs.
module tb_seven_seg_decoder;

  logic       clock;
  logic       reset;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_al;    // ACTIVE_LOW=1, HEX_EN=1
  logic [6:0] seg_nh;    // ACTIVE_LOW=1, HEX_EN=0
  logic [6:0] seg_ah;    // ACTIVE_LOW=0, HEX_EN=1

  int n_cmp;
  int n_fail;

  logic [6:0] exp_al [0:15];

  seven_seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_al (
    .clock(clock), .reset(reset), .digit(digit),
    .blank(blank), .lamp_test(lamp_test), .seg(seg_al));

  seven_seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_nh (
    .clock(clock), .reset(reset), .digit(digit),
    .blank(blank), .lamp_test(lamp_test), .seg(seg_nh));

  seven_seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_ah (
    .clock(clock), .reset(reset), .digit(digit),
    .blank(blank), .lamp_test(lamp_test), .seg(seg_ah));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    digit = 4'd5; blank = 1'b0; lamp_test = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (seg_al !== 7'h7F) begin n_fail++; $display("FAIL reset_async_al: got %h want 7f", seg_al); end
    n_cmp++;
    if (seg_ah !== 7'h00) begin n_fail++; $display("FAIL reset_async_ah: got %h want 00", seg_ah); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (seg_al !== 7'h12) begin n_fail++; $display("FAIL reset_release_5: got %h want 12", seg_al); end
    n_cmp++;
    if (seg_ah !== 7'h6D) begin n_fail++; $display("FAIL reset_release_5_ah: got %h want 6d", seg_ah); end
  endtask

  task automatic test_sweep();
    logic [6:0] prev;
    prev = seg_al;
    for (int i = 0; i < 16; i++) begin
      digit = i[3:0];
      #1;
      n_cmp++;
      if (seg_al !== prev) begin n_fail++; $display("FAIL sweep_latency d=%0d: got %h want %h", i, seg_al, prev); end
      tick();
      n_cmp++;
      if (seg_al !== exp_al[i]) begin n_fail++; $display("FAIL sweep_al d=%0d: got %h want %h", i, seg_al, exp_al[i]); end
      n_cmp++;
      if (i >= 10) begin
        if (seg_nh !== 7'h7F) begin n_fail++; $display("FAIL sweep_nohex d=%0d: got %h want 7f", i, seg_nh); end
      end else begin
        if (seg_nh !== exp_al[i]) begin n_fail++; $display("FAIL sweep_nohex d=%0d: got %h want %h", i, seg_nh, exp_al[i]); end
      end
      prev = exp_al[i];
    end
    digit = 4'd9;
    tick();
    n_cmp++;
    if (seg_nh !== 7'h10) begin n_fail++; $display("FAIL nohex_9: got %h want 10", seg_nh); end
  endtask

  task automatic test_overrides();
    digit = 4'd3; blank = 1'b1; lamp_test = 1'b0;
    tick();
    n_cmp++;
    if (seg_al !== 7'h7F) begin n_fail++; $display("FAIL blank_al: got %h want 7f", seg_al); end
    n_cmp++;
    if (seg_ah !== 7'h00) begin n_fail++; $display("FAIL blank_ah: got %h want 00", seg_ah); end
    lamp_test = 1'b1;
    tick();
    n_cmp++;
    if (seg_al !== 7'h00) begin n_fail++; $display("FAIL lamp_over_blank_al: got %h want 00", seg_al); end
    n_cmp++;
    if (seg_ah !== 7'h7F) begin n_fail++; $display("FAIL lamp_over_blank_ah: got %h want 7f", seg_ah); end
    blank = 1'b0; lamp_test = 1'b0;
    tick();
    n_cmp++;
    if (seg_al !== 7'h30) begin n_fail++; $display("FAIL overrides_drop: got %h want 30", seg_al); end
    digit = 4'd2;
    tick();
    n_cmp++;
    if (seg_ah !== 7'h5B) begin n_fail++; $display("FAIL ah_digit2: got %h want 5b", seg_ah); end
    lamp_test = 1'b1;
    tick();
    n_cmp++;
    if (seg_ah !== 7'h7F) begin n_fail++; $display("FAIL ah_lamp: got %h want 7f", seg_ah); end
    lamp_test = 1'b0;
  endtask

  task automatic test_async_reset();
    digit = 4'hE;
    tick();
    n_cmp++;
    if (seg_al !== 7'h06) begin n_fail++; $display("FAIL pre_reset_E: got %h want 06", seg_al); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (seg_al !== 7'h7F) begin n_fail++; $display("FAIL midcycle_reset_al: got %h want 7f", seg_al); end
    n_cmp++;
    if (seg_ah !== 7'h00) begin n_fail++; $display("FAIL midcycle_reset_ah: got %h want 00", seg_ah); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (seg_al !== 7'h7F) begin n_fail++; $display("FAIL reset_hold cyc=%0d: got %h want 7f", k, seg_al); end
    end
    digit = 4'd7;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (seg_al !== 7'h78) begin n_fail++; $display("FAIL reset_release_7: got %h want 78", seg_al); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [0:5];
    seq = '{4'd1, 4'hA, 4'd4, 4'hC, 4'd6, 4'hD};
    for (int j = 0; j < 6; j++) begin
      digit = seq[j];
      tick();
      n_cmp++;
      if (seg_al !== exp_al[seq[j]]) begin n_fail++; $display("FAIL b2b j=%0d: got %h want %h", j, seg_al, exp_al[seq[j]]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset();
    test_sweep();
    test_overrides();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
